// File: rtl/ccr_flag_unit.sv
// ccr_flag_unit: condition-code register {V,C,N,Z} with masked ALU commit,
// conditional-jump evaluation (taken jump clears the tested flag) and a LIFO
// shadow stack that preserves flags across nested interrupts.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   alu_flags/mask   {V,C,N,Z} ALU flags and per-bit update enables
//   alu_valid        ALU result committed this cycle
//   jmp_en/jmp_type  conditional jump in execute; type 00=Z 01=N 10=C 11=V
//   int_save         push CCR to the shadow stack
//   rti_restore      pop the shadow stack into the CCR
//   flags_out        registered CCR; cin_out is its C bit
//   jmp_taken        combinational from the registered CCR
//   depth            shadow entries in use; shadow_full/shadow_empty status
//   err_ovf/err_unf  sticky push-while-full / pop-while-empty errors
module ccr_flag_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    alu_flags,
    input  logic [3:0]    alu_mask,
    input  logic          alu_valid,
    input  logic          jmp_en,
    input  logic [1:0]    jmp_type,
    input  logic          int_save,
    input  logic          rti_restore,
    output logic [3:0]    flags_out,
    output logic          cin_out,
    output logic          jmp_taken,
    output logic [DW-1:0] depth,
    output logic          shadow_full,
    output logic          shadow_empty,
    output logic          err_ovf,
    output logic          err_unf
);

    logic [3:0]    ccr_q, ccr_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [3:0]    stack_q [DEPTH];
    logic [3:0]    stack_d [DEPTH];
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;

    logic [3:0]    upd;
    logic [3:0]    top;
    logic          full, empty;

    // jmp_type doubles as the bit index of the tested flag in {V,C,N,Z}.
    assign jmp_taken = jmp_en & ccr_q[jmp_type];

    always_comb begin
        full  = (depth_q == DW'(DEPTH));
        empty = (depth_q == '0);

        // Top-of-stack read via compare so the index never exceeds the array.
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) top = stack_q[i];
        end

        // AND with the mask keeps X on masked-off flag inputs out of the CCR.
        upd = ccr_q;
        if (alu_valid) upd = (ccr_q & ~alu_mask) | (alu_flags & alu_mask);
        // Clear follows the ALU merge so it wins on a same-bit collision.
        if (jmp_taken) upd[jmp_type] = 1'b0;

        ccr_d     = upd;
        depth_d   = depth_q;
        stack_d   = stack_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;

        if (int_save && rti_restore && !empty) begin
            // Swap: CCR takes the top, the top takes the pre-update CCR.
            ccr_d = top;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (depth_q == DW'(i + 1)) stack_d[i] = ccr_q;
            end
        end else begin
            if (int_save) begin
                if (!full) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (depth_q == DW'(i)) stack_d[i] = ccr_q;
                    end
                    depth_d = depth_q + DW'(1);
                end else begin
                    err_ovf_d = 1'b1;
                end
            end
            // Both requests at depth 0 land here: the push above stands,
            // the pop is refused and the CCR keeps the normal update.
            if (rti_restore) begin
                if (!empty) begin
                    ccr_d   = top;
                    depth_d = depth_q - DW'(1);
                end else begin
                    err_unf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q     <= '0;
            depth_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            ccr_q     <= ccr_d;
            depth_q   <= depth_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // Stack contents need no reset: entries above depth are never read.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    always_comb begin
        flags_out    = ccr_q;
        cin_out      = ccr_q[2];
        depth        = depth_q;
        shadow_full  = full;
        shadow_empty = empty;
        err_ovf      = err_ovf_q;
        err_unf      = err_unf_q;
    end

endmodule

// File: tb/tb_ccr_flag_unit.sv
module tb_ccr_flag_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    alu_flags, alu_mask;
    logic          alu_valid, jmp_en, int_save, rti_restore;
    logic [1:0]    jmp_type;
    logic [3:0]    flags_out;
    logic          cin_out, jmp_taken, shadow_full, shadow_empty, err_ovf, err_unf;
    logic [DW-1:0] depth;

    ccr_flag_unit #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_flags    (alu_flags),
        .alu_mask     (alu_mask),
        .alu_valid    (alu_valid),
        .jmp_en       (jmp_en),
        .jmp_type     (jmp_type),
        .int_save     (int_save),
        .rti_restore  (rti_restore),
        .flags_out    (flags_out),
        .cin_out      (cin_out),
        .jmp_taken    (jmp_taken),
        .depth        (depth),
        .shadow_full  (shadow_full),
        .shadow_empty (shadow_empty),
        .err_ovf      (err_ovf),
        .err_unf      (err_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    f;
        logic [DW-1:0] d;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // One cycle: drive inputs, check jmp_taken before the edge, queue the
    // expected registered state, then compare it after the edge.
    task automatic step(input logic r, input logic [3:0] f, input logic [3:0] m,
                        input logic v, input logic je, input logic [1:0] jt,
                        input logic sv, input logic rs, input logic ejt,
                        input logic [3:0] ef, input logic [DW-1:0] ed,
                        input logic eo, input logic eu);
        exp_t e;
        rst = r; alu_flags = f; alu_mask = m; alu_valid = v;
        jmp_en = je; jmp_type = jt; int_save = sv; rti_restore = rs;
        #1;
        if (!r) check("jmp_taken", {7'd0, jmp_taken}, {7'd0, ejt});
        e.f = ef; e.d = ed; e.ovf = eo; e.unf = eu;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check("flags_out", {4'd0, flags_out}, {4'd0, e.f});
            check("cin_out", {7'd0, cin_out}, {7'd0, e.f[2]});
            check("depth", {5'd0, depth}, {5'd0, e.d});
            check("shadow_full", {7'd0, shadow_full}, {7'd0, (e.d == DW'(DEPTH))});
            check("shadow_empty", {7'd0, shadow_empty}, {7'd0, (e.d == '0)});
            check("err_ovf", {7'd0, err_ovf}, {7'd0, e.ovf});
            check("err_unf", {7'd0, err_unf}, {7'd0, e.unf});
        end
    endtask

    initial begin
        rst = 1'b1; alu_flags = '0; alu_mask = '0; alu_valid = 1'b0;
        jmp_en = 1'b0; jmp_type = '0; int_save = 1'b0; rti_restore = 1'b0;
        @(posedge clk); #1;
        // Reset
        step(1, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 0, 0, 0);
        // Masked update, then hold on valid=0 and on mask=0000
        step(0, 4'b1111, 4'b0011, 1, 0, 2'b00, 0, 0, 0, 4'b0011, 0, 0, 0);
        step(0, 4'b1111, 4'b1111, 0, 0, 2'b00, 0, 0, 0, 4'b0011, 0, 0, 0);
        step(0, 4'b1111, 4'b0000, 1, 0, 2'b00, 0, 0, 0, 4'b0011, 0, 0, 0);
        // X safety on masked-off inputs
        step(0, 4'b1010, 4'b1111, 1, 0, 2'b00, 0, 0, 0, 4'b1010, 0, 0, 0);
        step(0, 4'bxx01, 4'b0011, 1, 0, 2'b00, 0, 0, 0, 4'b1001, 0, 0, 0);
        // Jumps: Z taken and cleared; C not taken
        step(0, 4'b0001, 4'b1111, 1, 0, 2'b00, 0, 0, 0, 4'b0001, 0, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 1, 2'b00, 0, 0, 1, 4'b0000, 0, 0, 0);
        step(0, 4'b0001, 4'b1111, 1, 0, 2'b00, 0, 0, 0, 4'b0001, 0, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 1, 2'b10, 0, 0, 0, 4'b0001, 0, 0, 0);
        // V and N bit mapping
        step(0, 4'b1111, 4'b1111, 1, 0, 2'b00, 0, 0, 0, 4'b1111, 0, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 1, 2'b11, 0, 0, 1, 4'b0111, 0, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 1, 2'b01, 0, 0, 1, 4'b0101, 0, 0, 0);
        // Collision: ALU sets C, taken JC clears it
        step(0, 4'b0100, 4'b1111, 1, 0, 2'b00, 0, 0, 0, 4'b0100, 0, 0, 0);
        step(0, 4'b0100, 4'b0100, 1, 1, 2'b10, 0, 0, 1, 4'b0000, 0, 0, 0);
        // Jump evaluates registered CCR, not the same-cycle ALU result
        step(0, 4'b0001, 4'b0001, 1, 1, 2'b00, 0, 0, 0, 4'b0001, 0, 0, 0);
        // Nesting: save pre-update CCR, restore overrides ALU
        step(0, 4'b0110, 4'b1111, 1, 0, 2'b00, 1, 0, 0, 4'b0110, 1, 0, 0);
        step(0, 4'b1000, 4'b1111, 1, 0, 2'b00, 1, 0, 0, 4'b1000, 2, 0, 0);
        step(0, 4'b1111, 4'b1111, 1, 0, 2'b00, 0, 1, 0, 4'b0110, 1, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0001, 0, 0, 0);
        // Swap at depth 1
        step(0, 4'b0010, 4'b1111, 1, 0, 2'b00, 1, 0, 0, 4'b0010, 1, 0, 0);
        step(0, 4'b1111, 4'b1111, 1, 0, 2'b00, 1, 1, 0, 4'b0001, 1, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0010, 0, 0, 0);
        // Bounds: fill, overflow, drain, underflow
        step(0, 4'b0001, 4'b1111, 1, 0, 2'b00, 1, 0, 0, 4'b0001, 1, 0, 0);
        step(0, 4'b0011, 4'b1111, 1, 0, 2'b00, 1, 0, 0, 4'b0011, 2, 0, 0);
        step(0, 4'b0111, 4'b1111, 1, 0, 2'b00, 1, 0, 0, 4'b0111, 3, 0, 0);
        step(0, 4'b1111, 4'b1111, 1, 0, 2'b00, 1, 0, 0, 4'b1111, 4, 0, 0);
        step(0, 4'b1000, 4'b1111, 1, 0, 2'b00, 1, 0, 0, 4'b1000, 4, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0111, 3, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0011, 2, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0001, 1, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0010, 0, 1, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0010, 0, 1, 1);
        // Restore while empty still takes the ALU update
        step(0, 4'b1000, 4'b1000, 1, 0, 2'b00, 0, 1, 0, 4'b1010, 0, 1, 1);
        // Reset clears sticky errors and depth
        step(1, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 0, 0, 0);
        // Save+restore at depth 0: push only, underflow flagged
        step(0, 4'b0010, 4'b1111, 1, 0, 2'b00, 0, 0, 0, 4'b0010, 0, 0, 0);
        step(0, 4'b0100, 4'b0100, 1, 0, 2'b00, 1, 1, 0, 4'b0110, 1, 0, 1);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0010, 0, 0, 1);
        // Reset mid-nesting discards entries
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 1, 0, 0, 4'b0010, 1, 0, 1);
        step(1, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 0, 0, 4'b0000, 0, 0, 0);
        step(0, 4'b0000, 4'b0000, 0, 0, 2'b00, 0, 1, 0, 4'b0000, 0, 0, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
